apb_master_bridge: RTL
======================

# apb_master_bridge

APB3 requester that converts a simple valid/ready command port into correctly sequenced APB SETUP/ACCESS transfers. It drives `psel`, `penable`, `paddr`, `pwrite` and `pwdata` into the downstream APB slave. It then waits on the slave's `pready`, which the slave may hold low for a random number of cycles. When the transfer finishes it returns read data and an error flag on a one-cycle response pulse. It sits directly upstream of the APB slave and replaces the dummy master used in the slave testbench.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 16, maximum ACCESS cycles with `pready` low before abort; 0 disables the timeout

Ports:
- `pclk`  in  1  system clock
- `preset`  in  1  reset: asynchronous, active-low
- `req_valid`  in  1  command valid
- `req_ready`  out  1  command accepted when both are high at a rising edge
- `req_addr`  in  ADDR_W  target address
- `req_write`  in  1  1 = write, 0 = read
- `req_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and errors
- `rsp_err`  out  1  `pslverr` or timeout, qualified by `rsp_valid`
- `psel`  out  1  APB select
- `penable`  out  1  APB enable
- `paddr`  out  ADDR_W  APB address
- `pwrite`  out  1  APB direction
- `pwdata`  out  DATA_W  APB write data
- `prdata`  in  DATA_W  APB read data
- `pready`  in  1  APB slave ready
- `pslverr`  in  1  APB slave error, sampled only with `pready`

## Operation
- The FSM has three states: IDLE, SETUP, ACCESS.
- **IDLE**
  - `req_ready` = 1; `psel` = 0; `penable` = 0.
  - On `req_valid` && `req_ready`: register `req_addr`, `req_write` and `req_wdata` into `paddr`, `pwrite` and `pwdata`, then go to SETUP.
- **SETUP**
  - `psel` = 1, `penable` = 0, `req_ready` = 0.
  - Lasts exactly one cycle, then goes unconditionally to ACCESS.
- **ACCESS**
  - `psel` = 1, `penable` = 1, `req_ready` = 0.
  - `paddr`, `pwrite` and `pwdata` stay stable throughout.
  - `pready` = 1 at the edge: complete the transfer and go to IDLE.
    - `rsp_valid` = 1 for one cycle.
    - `rsp_err` = `pslverr`.
    - `rsp_rdata` = `prdata` if the transfer was a read and `pslverr` = 0; otherwise 0.
  - `pready` = 0: increment the wait counter.
    - When the counter reaches TIMEOUT (TIMEOUT > 0), abort: `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0, go to IDLE.
    - The abort drops `psel` and `penable` together.
  - The wait counter clears on entry to SETUP. Its width is clog2(TIMEOUT+1), and it saturates and never wraps.
- After a transfer, `paddr`, `pwrite` and `pwdata` hold their last values. They are never driven to X or 0. The downstream slave decodes `paddr` continuously, so a spurious address change must not occur.
- `rsp_rdata` and `rsp_err` hold their value between pulses.
- Commands presented in SETUP or ACCESS are not accepted. `req_ready` is a combinational decode of state == IDLE.
- There is no back-to-back ACCESS→SETUP path. The minimum gap is one IDLE cycle.

## Timing
- Reset values:
  - `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_err`: 0.
  - `paddr`, `pwdata`, `rsp_rdata`: 0.
  - State: IDLE, so `req_ready` = 1.
- Cycle numbering is from the accept edge E0:
  - SETUP is visible in cycle 1.
  - ACCESS is visible from cycle 2.
  - With zero wait states, `pready` is sampled high at E2 and `rsp_valid` is high in cycle 3.
  - `req_ready` returns high in cycle 3.
  - Minimum transfer period is 3 cycles.
- Each wait cycle (`pready` low at an ACCESS edge) adds one cycle.
- A timeout asserts `rsp_valid` in the cycle after the TIMEOUT-th low-`pready` ACCESS edge.
- Reset mid-transfer:
  - `psel` and `penable` drop immediately, asynchronously.
  - No response is issued.
  - The pending command is discarded.
- If `pready` and the timeout terminal count occur on the same edge, `pready` wins and the normal completion is reported.
- All outputs are registered except `req_ready`.

## Structure
- Package `apb_pkg`:
  - State encoding constants `APB_IDLE` = 2'b00, `APB_SETUP` = 2'b10, `APB_ACCESS` = 2'b11. These match the {psel,penable} encoding used by the slave.
  - Default width constants.
- Sub-module `apb_wait_timer`:
  - Inputs: clear, count-enable, TIMEOUT parameter.
  - Output: registered `expired` flag.
  - Instantiated once.

## Test plan
- **Write, zero wait:** `req_addr` = 32'hFFFF_FFFF, `req_wdata` = 32'hA5A5_0001, `pready` tied 1 → SETUP in cycle 1, ACCESS in cycle 2; `rsp_valid` in cycle 3 with `rsp_err` = 0 and `rsp_rdata` = 0; `pwdata` stable over cycles 1–2.
- **Read, 3 wait states:** `pready` low for 3 ACCESS edges, then high with `prdata` = 32'h1234_5678 → `rsp_valid` in cycle 6 with `rsp_rdata` = 32'h1234_5678.
- **Timeout:** TIMEOUT = 4, `pready` held 0 → `rsp_err` = 1 and `rsp_rdata` = 0 after the 4th low edge; `psel` drops; the next command is accepted normally.
- **Slave error:** `pready` = 1 and `pslverr` = 1 on a read → `rsp_err` = 1, `rsp_rdata` = 0.
- **Reset mid-ACCESS:** `preset` asserted low while `pready` is held low → `psel` and `penable` = 0 immediately; no `rsp_valid`; `req_ready` = 1 after release.
- **Back-to-back with the paired APB slave model:** 20 random read/write commands with `req_valid` held high → each transfer is separated by exactly one IDLE cycle; responses arrive in order; data matches a scoreboard.

Source files
------------

// File: rtl/apb_pkg.sv
//------------------------------------------------------------------------------
// Module : apb_pkg
// Brief  : APB requester state encoding and default widths.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Encoding is {psel, penable}, so the state register drives the bus directly
  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b10,
    APB_ACCESS = 2'b11
  } apb_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_wait_timer.sv
//------------------------------------------------------------------------------
// Module : apb_wait_timer
// Brief  : Saturating ACCESS wait counter; o_expired is high when the next
//          counted edge is the terminal (TIMEOUT-th) one.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  generate
    if (TIMEOUT > 0) begin : g_timer
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(TIMEOUT);

      logic [CNT_W-1:0] r_cnt;
      logic             r_expired;

      // Flag is pre-armed one edge early so the abort lands on the terminal edge
      always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
          r_cnt     <= '0;
          r_expired <= 1'b0;
        end else if (i_clear) begin
          r_cnt     <= '0;
          r_expired <= (TIMEOUT == 1);
        end else if (i_en) begin
          if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
          r_expired <= ((int'(r_cnt) + 2) >= TIMEOUT);
        end
      end

      assign o_expired = r_expired;
    end else begin : g_no_timer
      logic w_unused;
      assign w_unused  = ^{pclk, preset, i_clear, i_en};
      assign o_expired = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge.sv
//------------------------------------------------------------------------------
// Module : apb_master_bridge
// Brief  : valid/ready command port to APB3 SETUP/ACCESS requester.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e r_state;
  apb_state_e w_next;
  logic       w_accept;
  logic       w_done;
  logic       w_abort;
  logic       w_count;
  logic       w_expired;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state <= APB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      APB_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = APB_SETUP;
        end
      end
      APB_SETUP: begin
        w_next = APB_ACCESS;
      end
      APB_ACCESS: begin
        // pready takes priority over a coincident terminal count
        if (pready) begin
          w_done = 1'b1;
          w_next = APB_IDLE;
        end else if (w_expired) begin
          w_abort = 1'b1;
          w_next  = APB_IDLE;
        end
      end
      default: begin
        w_next = APB_IDLE;
      end
    endcase
  end

  assign req_ready = (r_state == APB_IDLE);
  assign psel      = r_state[1];
  assign penable   = r_state[0];
  assign w_count   = (r_state == APB_ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .pclk      (pclk),
    .preset    (preset),
    .i_clear   (w_accept),
    .i_en      (w_count),
    .o_expired (w_expired)
  );

  // Bus address/data only change on accept so the slave never sees a glitch
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= w_done | w_abort;
      if (w_accept) begin
        paddr  <= req_addr;
        pwrite <= req_write;
        pwdata <= req_wdata;
      end
      if (w_done) begin
        rsp_err   <= pslverr;
        rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
      end else if (w_abort) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

`default_nettype wire
